alu_exec_ctrl: RTL and testbench
================================

ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 Parameter TRAP_EN, default 1: 1 = signed-overflow trap enabled for add/sub; 0 = trap never raised.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  request from main control FSM; sampled only in IDLE.
REQ-005 aluop  in  3  000 ADD, 001 SUB, 010 RTYPE, 011 AND, 100 OR, 101 XOR, 110 SLTU, 111 EQ-compare.
REQ-006 funct  in  6  R-type function field, used when aluop=010.
REQ-007 a_reg, b_reg  in  32 each  operand registers from register file.
REQ-008 imm  in  16  immediate field.
REQ-009 srcb_sel  in  2  B operand: 00 b_reg, 01 sign-extended imm, 10 zero-extended imm, 11 constant 4.
REQ-010 alu_a, alu_b  out  32 each  operands to ALU (registered).
REQ-011 alu_func  out  6  ALU function code (registered).
REQ-012 alu_o  in  32; alu_ov  in  1  ALU result and flag.
REQ-013 alu_out  out  32  registered result (ALUOut).
REQ-014 flag  out  1  registered compare/carry flag.
REQ-015 ovf_exc, ill_exc  out  1 each  overflow / illegal-funct exception, valid with done.
REQ-016 busy  out  1  high in OPER and RES; done  out  1  one-cycle completion pulse.

Function
REQ-017 FSM states IDLE, OPER, RES; IDLE->OPER on start, OPER->RES unconditionally, RES->IDLE unconditionally.
REQ-018 On start in IDLE: capture a_reg into alu_a, selected B into alu_b, decoded code into alu_func; inputs ignored after that edge.
REQ-019 Latency: start sampled at edge N; alu_out/flag/exceptions update at edge N+2; done high for exactly the cycle after edge N+2.
REQ-020 start while busy or during done cycle is ignored, no queueing; start in the done cycle (state IDLE) is accepted.
REQ-021 Codes: ADD 000010, SUB 000100, AND 001000, OR 010000, NOR 100000, SLT 001001, SLTU 000101, XOR 010001, EQ 100011 (flag=1 when A==B).
REQ-022 RTYPE decode: 100000 add(trap), 100001 addu, 100010 sub(trap), 100011 subu, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt, 101011 sltu.
REQ-023 Any other funct under RTYPE: ill_exc=1 with done, alu_out and flag unchanged, ALU code driven is ADD.
REQ-024 aluop ADD/SUB (non-RTYPE) are non-trapping (address, PC+4 arithmetic).
REQ-025 Signed overflow computed by this block from alu_a[31], alu_b[31], alu_o[31]: add = operands same sign, result differs; sub = operands differ, result sign differs from A.
REQ-026 Trapping op with overflow and TRAP_EN=1: ovf_exc=1, alu_out NOT updated; otherwise alu_out <= alu_o.
REQ-027 flag <= alu_ov for ADD/SUB (carry/borrow-out) and EQ; 0 for all other ops.
REQ-028 ovf_exc and ill_exc are 0 except in the done cycle.

Reset
REQ-029 rst_n low: immediately state IDLE; alu_a, alu_b, alu_out = 0; alu_func = 000010; flag, ovf_exc, ill_exc, busy, done = 0.
REQ-030 Reset mid-operation aborts; no done pulse; first start after release proceeds normally.

Verification
REQ-031 aluop=000, a=0x00000005, srcb_sel=01, imm=0xFFFF -> alu_func 000010, alu_b 0xFFFFFFFF, alu_out 0x00000004, flag 1, done at N+2.
REQ-032 RTYPE funct 100000, a=0x7FFFFFFF, b=1 -> ovf_exc=1, alu_out holds previous value; same with funct 100001 -> alu_out 0x80000000, ovf_exc 0.
REQ-033 aluop=111, a=b=0x1234ABCD -> flag 1; b=0x1234ABCC -> flag 0; alu_func 100011 both.
REQ-034 RTYPE funct 101010, a=0xFFFFFFFF, b=1 -> alu_out 1; funct 101011 same operands -> alu_out 0; funct 111111 -> ill_exc 1.
REQ-035 start held high 6 cycles -> exactly two operations, done pulses at cycles 3 and 6; second start during busy ignored.
REQ-036 rst_n low in OPER -> all outputs to reset values asynchronously, no done; next start completes with correct result.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: ALU execute sequencer (start/aluop/funct/operands in -> registered alu_a/alu_b/alu_func to ALU, alu_o/alu_ov back -> alu_out/flag/ovf_exc/ill_exc, busy/done)
module alu_exec_ctrl #(
  parameter bit TRAP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  aluop,
  input  logic [5:0]  funct,
  input  logic [31:0] a_reg,
  input  logic [31:0] b_reg,
  input  logic [15:0] imm,
  input  logic [1:0]  srcb_sel,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_func,
  input  logic [31:0] alu_o,
  input  logic        alu_ov,
  output logic [31:0] alu_out,
  output logic        flag,
  output logic        ovf_exc,
  output logic        ill_exc,
  output logic        busy,
  output logic        done
);
  localparam logic [5:0] F_ADD = 6'b000010, F_SUB = 6'b000100, F_AND = 6'b001000,
                         F_OR = 6'b010000, F_NOR = 6'b100000, F_SLT = 6'b001001,
                         F_SLTU = 6'b000101, F_XOR = 6'b010001, F_EQ = 6'b100011;
  typedef enum logic [1:0] {IDLE, OPER, RES} state_t;
  state_t      state_q, state_d;
  logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, alu_out_q, alu_out_d, b_sel;
  logic [5:0]  alu_func_q, alu_func_d, dec_func;
  logic        flag_q, flag_d, ovf_q, ovf_d, ill_q, ill_d, busy_q, busy_d, done_q, done_d;
  logic        trap_q, trap_d, bad_q, bad_d, dec_trap, dec_bad, take, fin, ovf;
  always_comb begin
    dec_func = F_ADD;
    dec_trap = 1'b0;
    dec_bad  = 1'b0;
    case (aluop)
      3'b000: dec_func = F_ADD;
      3'b001: dec_func = F_SUB;
      3'b011: dec_func = F_AND;
      3'b100: dec_func = F_OR;
      3'b101: dec_func = F_XOR;
      3'b110: dec_func = F_SLTU;
      3'b111: dec_func = F_EQ;
      default:
        case (funct)
          6'b100000: begin dec_func = F_ADD; dec_trap = 1'b1; end
          6'b100001: dec_func = F_ADD;
          6'b100010: begin dec_func = F_SUB; dec_trap = 1'b1; end
          6'b100011: dec_func = F_SUB;
          6'b100100: dec_func = F_AND;
          6'b100101: dec_func = F_OR;
          6'b100110: dec_func = F_XOR;
          6'b100111: dec_func = F_NOR;
          6'b101010: dec_func = F_SLT;
          6'b101011: dec_func = F_SLTU;
          default:   dec_bad = 1'b1;
        endcase
    endcase
  end
  always_comb begin
    take  = (state_q == IDLE) && start;
    fin   = (state_q == RES);
    b_sel = srcb_sel == 2'b00 ? b_reg :
            srcb_sel == 2'b01 ? {{16{imm[15]}}, imm} :
            srcb_sel == 2'b10 ? {16'h0000, imm} : 32'd4;
    // add: operand signs equal; sub: operand signs differ; both: result sign departs from A
    ovf   = TRAP_EN && trap_q && (alu_o[31] != alu_a_q[31]) &&
            ((alu_a_q[31] ^ alu_b_q[31]) == (alu_func_q == F_SUB));
    state_d    = state_q == IDLE ? (start ? OPER : IDLE) : state_q == OPER ? RES : IDLE;
    alu_a_d    = take ? a_reg : alu_a_q;
    alu_b_d    = take ? b_sel : alu_b_q;
    alu_func_d = take ? dec_func : alu_func_q;
    trap_d     = take ? dec_trap : trap_q;
    bad_d      = take ? dec_bad : bad_q;
    alu_out_d  = fin && !bad_q && !ovf ? alu_o : alu_out_q;
    flag_d     = fin && !bad_q ? alu_ov && (alu_func_q == F_ADD || alu_func_q == F_SUB || alu_func_q == F_EQ) : flag_q;
    ovf_d      = fin && !bad_q && ovf;
    ill_d      = fin && bad_q;
    done_d     = fin;
    busy_d     = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_func_q <= F_ADD;
      alu_out_q  <= '0;
      flag_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ill_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      trap_q     <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_func_q <= alu_func_d;
      alu_out_q  <= alu_out_d;
      flag_q     <= flag_d;
      ovf_q      <= ovf_d;
      ill_q      <= ill_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      trap_q     <= trap_d;
      bad_q      <= bad_d;
    end
  end
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_func = alu_func_q;
  assign alu_out  = alu_out_q;
  assign flag     = flag_q;
  assign ovf_exc  = ovf_q;
  assign ill_exc  = ill_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: randomized check of alu_exec_ctrl against an arithmetic reference model
module tb_alu_exec_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [2:0]  aluop = '0;
  logic [5:0]  funct = '0;
  logic [31:0] a_reg = '0, b_reg = '0;
  logic [15:0] imm = '0;
  logic [1:0]  srcb_sel = '0;
  logic [31:0] alu_a, alu_b, alu_o, alu_out;
  logic [5:0]  alu_func;
  logic        alu_ov, flag, ovf_exc, ill_exc, busy, done;
  int          n_vec = 0, n_err = 0;
  logic [31:0] exp_out = '0;
  logic        exp_flag = 1'b0;
  alu_exec_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .aluop(aluop), .funct(funct),
    .a_reg(a_reg), .b_reg(b_reg), .imm(imm), .srcb_sel(srcb_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_o(alu_o), .alu_ov(alu_ov),
    .alu_out(alu_out), .flag(flag), .ovf_exc(ovf_exc), .ill_exc(ill_exc),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always_comb begin
    alu_o  = '0;
    alu_ov = 1'b0;
    case (alu_func)
      6'b000010: {alu_ov, alu_o} = {1'b0, alu_a} + {1'b0, alu_b};
      6'b000100: begin alu_o = alu_a - alu_b; alu_ov = alu_a < alu_b; end
      6'b001000: alu_o = alu_a & alu_b;
      6'b010000: alu_o = alu_a | alu_b;
      6'b100000: alu_o = ~(alu_a | alu_b);
      6'b010001: alu_o = alu_a ^ alu_b;
      6'b001001: alu_o = {31'b0, $signed(alu_a) < $signed(alu_b)};
      6'b000101: alu_o = {31'b0, alu_a < alu_b};
      6'b100011: begin alu_o = {31'b0, alu_a == alu_b}; alu_ov = alu_a == alu_b; end
      default: ;
    endcase
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic do_op(input logic [2:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] im, input logic [1:0] sel);
    logic [31:0] bv, r;
    logic [5:0]  code;
    logic        fl, trap, ill, ov, is_sub;
    longint      s;
    bv = sel == 0 ? b : sel == 1 ? {{16{im[15]}}, im} : sel == 2 ? {16'h0, im} : 32'd4;
    ill = 0; trap = 0; is_sub = 0; fl = 0; code = 6'b000010; r = '0;
    case ({op, (op == 3'b010) ? fn : 6'h00})
      {3'b000, 6'h00}, {3'b010, 6'h21}: r = a + bv;
      {3'b010, 6'h20}: begin r = a + bv; trap = 1; end
      {3'b001, 6'h00}, {3'b010, 6'h23}: begin r = a - bv; is_sub = 1; code = 6'b000100; end
      {3'b010, 6'h22}: begin r = a - bv; is_sub = 1; trap = 1; code = 6'b000100; end
      {3'b011, 6'h00}, {3'b010, 6'h24}: begin r = a & bv; code = 6'b001000; end
      {3'b100, 6'h00}, {3'b010, 6'h25}: begin r = a | bv; code = 6'b010000; end
      {3'b101, 6'h00}, {3'b010, 6'h26}: begin r = a ^ bv; code = 6'b010001; end
      {3'b010, 6'h27}: begin r = ~(a | bv); code = 6'b100000; end
      {3'b010, 6'h2A}: begin r = 32'($signed(a) < $signed(bv)); code = 6'b001001; end
      {3'b110, 6'h00}, {3'b010, 6'h2B}: begin r = 32'(a < bv); code = 6'b000101; end
      {3'b111, 6'h00}: begin r = 32'(a == bv); fl = a == bv; code = 6'b100011; end
      default: ill = 1;
    endcase
    if (code == 6'b000010) fl = (64'(a) + 64'(bv)) > 64'hFFFF_FFFF;
    if (code == 6'b000100) fl = a < bv;
    s  = is_sub ? longint'($signed(a)) - longint'($signed(bv)) : longint'($signed(a)) + longint'($signed(bv));
    ov = trap && (s > 64'sd2147483647 || s < -64'sd2147483648);
    @(negedge clk);
    aluop = op; funct = fn; a_reg = a; b_reg = b; imm = im; srcb_sel = sel; start = 1;
    @(posedge clk); #1;
    start = 0; aluop = 3'($urandom); funct = 6'($urandom); a_reg = $urandom; b_reg = $urandom; imm = 16'($urandom); srcb_sel = 2'($urandom);
    chk("busy_oper", busy, 1);
    chk("alu_a", alu_a, a);
    chk("alu_b", alu_b, bv);
    chk("alu_func", alu_func, code);
    @(posedge clk); #1;
    chk("done_early", done, 0);
    chk("exc_early", {ovf_exc, ill_exc}, 0);
    chk("busy_res", busy, 1);
    @(posedge clk); #1;
    if (!ill) begin
      exp_flag = fl;
      if (!ov) exp_out = r;
    end
    chk("done", done, 1);
    chk("busy_done", busy, 0);
    chk("alu_out", alu_out, exp_out);
    chk("flag", flag, exp_flag);
    chk("ovf_exc", ovf_exc, ov);
    chk("ill_exc", ill_exc, ill);
  endtask
  function automatic logic [31:0] rnd32();
    logic [31:0] sp [4] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h00000001};
    return ($urandom % 3 == 0) ? sp[$urandom % 4] : $urandom;
  endfunction
  task automatic chk_reset(input string tag);
    chk({tag, "_a"}, alu_a, 0);
    chk({tag, "_b"}, alu_b, 0);
    chk({tag, "_func"}, alu_func, 6'b000010);
    chk({tag, "_out"}, alu_out, 0);
    chk({tag, "_bits"}, {flag, ovf_exc, ill_exc, busy, done}, 0);
  endtask
  initial begin
    logic [5:0]  legal [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    logic [5:0]  d;
    logic [31:0] a1, a2, b1;
    #12 chk_reset("rst");
    @(negedge clk); rst_n = 1;
    do_op(3'b000, 6'h00, 32'h5, 32'h0, 16'hFFFF, 2'b01);
    do_op(3'b010, 6'h20, 32'h7FFFFFFF, 32'h1, 16'h0, 2'b00);
    do_op(3'b010, 6'h21, 32'h7FFFFFFF, 32'h1, 16'h0, 2'b00);
    do_op(3'b111, 6'h00, 32'h1234ABCD, 32'h1234ABCD, 16'h0, 2'b00);
    do_op(3'b111, 6'h00, 32'h1234ABCD, 32'h1234ABCC, 16'h0, 2'b00);
    do_op(3'b010, 6'h2A, 32'hFFFFFFFF, 32'h1, 16'h0, 2'b00);
    do_op(3'b010, 6'h2B, 32'hFFFFFFFF, 32'h1, 16'h0, 2'b00);
    do_op(3'b010, 6'h3F, 32'hFFFFFFFF, 32'h1, 16'h0, 2'b00);
    do_op(3'b010, 6'h22, 32'h80000000, 32'h1, 16'h0, 2'b00);
    do_op(3'b001, 6'h00, 32'h3, 32'h0, 16'h8000, 2'b10);
    do_op(3'b000, 6'h00, 32'h1000, 32'h0, 16'h0, 2'b11);
    a1 = $urandom; a2 = $urandom; b1 = $urandom;
    @(negedge clk);
    aluop = 3'b000; srcb_sel = 2'b00; a_reg = a1; b_reg = b1; start = 1; d = '0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      d[i-1] = done;
      if (i == 1) a_reg = a2;
      if (i == 3) chk("hold_out1", alu_out, a1 + b1);
    end
    start = 0;
    chk("hold_done", d, 6'b100100);
    chk("hold_out2", alu_out, a2 + b1);
    exp_out = a2 + b1;
    exp_flag = (64'(a2) + 64'(b1)) > 64'hFFFF_FFFF;
    @(posedge clk); #1 chk("hold_idle", {busy, done}, 0);
    @(negedge clk);
    aluop = 3'b011; a_reg = 32'hFFFF0000; b_reg = 32'h0F0F0F0F; srcb_sel = 2'b00; start = 1;
    @(posedge clk); #1 start = 0;
    #2 rst_n = 0;
    #1 chk_reset("arst");
    exp_out = '0; exp_flag = 0;
    @(negedge clk); rst_n = 1;
    d = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 d[i] = done;
    end
    chk("arst_nodone", d, 0);
    do_op(3'b011, 6'h00, 32'hFFFF0000, 32'h0F0F0F0F, 16'h0, 2'b00);
    for (int i = 0; i < 80; i++)
      do_op(3'($urandom), ($urandom % 4 == 0) ? 6'($urandom) : legal[$urandom % 10],
            rnd32(), rnd32(), 16'($urandom), 2'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
